// File: rtl/multi_alarm_clock.sv
// ============================================================================
// Module   : multi_alarm_clock
// Brief    : 24-hour BCD time-of-day clock with N alarm slots sharing one
//            ring / snooze / auto-timeout controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_alarm_clock #(
    parameter int CLK_DIV    = 1,
    parameter int N_ALARMS   = 4,
    parameter int SEL_W      = 2,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          H_in1,
    input  logic [3:0]          H_in0,
    input  logic [3:0]          M_in1,
    input  logic [3:0]          M_in0,
    input  logic                LD_time,
    input  logic                LD_alarm,
    input  logic [SEL_W-1:0]    al_sel,
    input  logic [N_ALARMS-1:0] AL_EN,
    input  logic                STOP_al,
    input  logic                SNOOZE,
    output logic                Alarm,
    output logic [N_ALARMS-1:0] Alarm_id,
    output logic [1:0]          H_out1,
    output logic [3:0]          H_out0,
    output logic [3:0]          M_out1,
    output logic [3:0]          M_out0,
    output logic [3:0]          S_out1,
    output logic [3:0]          S_out0
);

    localparam int              c_pw          = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_pw-1:0] c_presc_last  = c_pw'(CLK_DIV - 1);
    localparam logic [7:0]      c_ring_last   = 8'(RING_SEC - 1);
    localparam logic [9:0]      c_snooze_load = 10'(SNOOZE_MIN * 60);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_ring    = 2'd1;
    localparam logic [1:0] c_st_snoozed = 2'd2;

    logic [c_pw-1:0]     r_presc;
    logic [1:0]          r_h1;
    logic [3:0]          r_h0, r_m1, r_m0, r_s1, r_s0;
    logic [1:0]          r_state;
    logic [N_ALARMS-1:0] r_mask;
    logic [7:0]          r_ring_tmr;
    logic [9:0]          r_snz_cnt;
    logic                r_alarm;

    logic                w_tick;
    logic                w_in_ok;
    logic                w_ld_time;
    logic                w_ld_alarm;
    logic                w_sec_wrap;
    logic [1:0]          w_nh1;
    logic [3:0]          w_nh0, w_nm1, w_nm0, w_ns1, w_ns0;
    logic [13:0]         w_next_hm;
    logic [N_ALARMS-1:0] w_match;
    logic [N_ALARMS-1:0] w_kept;
    logic [N_ALARMS-1:0] w_merged;
    logic [1:0]          w_state_nx;
    logic [N_ALARMS-1:0] w_mask_nx;
    logic [7:0]          w_ring_tmr_nx;
    logic [9:0]          w_snz_cnt_nx;

    assign w_tick     = (r_presc == c_presc_last);
    assign w_in_ok    = ((H_in1 < 2'd2 && H_in0 <= 4'd9) || (H_in1 == 2'd2 && H_in0 <= 4'd3))
                        && (M_in1 <= 4'd5) && (M_in0 <= 4'd9);
    // LD_time shadows LD_alarm when both are strobed together
    assign w_ld_time  = LD_time && w_in_ok;
    assign w_ld_alarm = LD_alarm && !LD_time && w_in_ok;
    assign w_sec_wrap = (r_s1 == 4'd5) && (r_s0 == 4'd9);

    always_comb begin
        w_nh1 = r_h1;
        w_nh0 = r_h0;
        w_nm1 = r_m1;
        w_nm0 = r_m0;
        w_ns1 = r_s1;
        w_ns0 = r_s0;
        if (r_s0 != 4'd9) begin
            w_ns0 = r_s0 + 4'd1;
        end else begin
            w_ns0 = 4'd0;
            if (r_s1 != 4'd5) begin
                w_ns1 = r_s1 + 4'd1;
            end else begin
                w_ns1 = 4'd0;
                if (r_m0 != 4'd9) begin
                    w_nm0 = r_m0 + 4'd1;
                end else begin
                    w_nm0 = 4'd0;
                    if (r_m1 != 4'd5) begin
                        w_nm1 = r_m1 + 4'd1;
                    end else begin
                        w_nm1 = 4'd0;
                        if (r_h1 == 2'd2 && r_h0 == 4'd3) begin
                            w_nh1 = 2'd0;
                            w_nh0 = 4'd0;
                        end else if (r_h0 == 4'd9) begin
                            w_nh1 = r_h1 + 2'd1;
                            w_nh0 = 4'd0;
                        end else begin
                            w_nh0 = r_h0 + 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign w_next_hm = {w_nh1, w_nh0, w_nm1, w_nm0};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_h1    <= 2'd0;
            r_h0    <= 4'd0;
            r_m1    <= 4'd0;
            r_m0    <= 4'd0;
            r_s1    <= 4'd0;
            r_s0    <= 4'd0;
        end else if (w_ld_time) begin
            r_presc <= '0;
            r_h1    <= H_in1;
            r_h0    <= H_in0;
            r_m1    <= M_in1;
            r_m0    <= M_in0;
            r_s1    <= 4'd0;
            r_s0    <= 4'd0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + c_pw'(1);
            if (w_tick) begin
                r_h1 <= w_nh1;
                r_h0 <= w_nh0;
                r_m1 <= w_nm1;
                r_m0 <= w_nm0;
                r_s1 <= w_ns1;
                r_s0 <= w_ns0;
            end
        end
    end

    // A slot matches only on the tick that rolls the display onto HH:MM:00
    for (genvar k = 0; k < N_ALARMS; k++) begin : g_slot
        logic [13:0] r_slot;
        logic        w_ld_slot;

        assign w_ld_slot = w_ld_alarm && (al_sel == SEL_W'(k));

        always_ff @(posedge clk) begin
            if (reset) begin
                r_slot <= 14'd0;
            end else if (w_ld_slot) begin
                r_slot <= {H_in1, H_in0, M_in1, M_in0};
            end
        end

        assign w_match[k] = w_tick && !w_ld_time && w_sec_wrap && AL_EN[k]
                            && (w_next_hm == r_slot);
    end

    assign w_kept   = r_mask & AL_EN;
    assign w_merged = w_kept | w_match;

    always_comb begin
        w_state_nx    = r_state;
        w_mask_nx     = r_mask;
        w_ring_tmr_nx = r_ring_tmr;
        w_snz_cnt_nx  = r_snz_cnt;
        case (r_state)
            c_st_idle: begin
                w_mask_nx = '0;
                if (|w_match) begin
                    w_state_nx    = c_st_ring;
                    w_mask_nx     = w_match;
                    w_ring_tmr_nx = 8'd0;
                end
            end
            c_st_ring: begin
                if (STOP_al || (w_merged == '0)) begin
                    w_state_nx = c_st_idle;
                    w_mask_nx  = '0;
                end else if (SNOOZE) begin
                    w_state_nx   = c_st_snoozed;
                    w_mask_nx    = w_merged;
                    w_snz_cnt_nx = c_snooze_load;
                end else if (|w_match) begin
                    w_mask_nx     = w_merged;
                    w_ring_tmr_nx = 8'd0;
                end else begin
                    w_mask_nx = w_kept;
                    if (w_tick) begin
                        if (r_ring_tmr == c_ring_last) begin
                            w_state_nx = c_st_idle;
                            w_mask_nx  = '0;
                        end else begin
                            w_ring_tmr_nx = r_ring_tmr + 8'd1;
                        end
                    end
                end
            end
            c_st_snoozed: begin
                if (STOP_al || (w_merged == '0)) begin
                    w_state_nx = c_st_idle;
                    w_mask_nx  = '0;
                end else if (|w_match) begin
                    w_state_nx    = c_st_ring;
                    w_mask_nx     = w_merged;
                    w_ring_tmr_nx = 8'd0;
                end else begin
                    w_mask_nx = w_kept;
                    if (w_tick) begin
                        // the tick that would bring the counter to zero re-arms the ring
                        if (r_snz_cnt == 10'd1) begin
                            w_state_nx    = c_st_ring;
                            w_ring_tmr_nx = 8'd0;
                        end else begin
                            w_snz_cnt_nx = r_snz_cnt - 10'd1;
                        end
                    end
                end
            end
            default: begin
                w_state_nx = c_st_idle;
                w_mask_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_mask     <= '0;
            r_ring_tmr <= 8'd0;
            r_snz_cnt  <= 10'd0;
            r_alarm    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_mask     <= w_mask_nx;
            r_ring_tmr <= w_ring_tmr_nx;
            r_snz_cnt  <= w_snz_cnt_nx;
            r_alarm    <= (w_state_nx == c_st_ring);
        end
    end

    assign Alarm    = r_alarm;
    assign Alarm_id = r_mask;
    assign H_out1   = r_h1;
    assign H_out0   = r_h0;
    assign M_out1   = r_m1;
    assign M_out0   = r_m0;
    assign S_out1   = r_s1;
    assign S_out0   = r_s0;

endmodule

`default_nettype wire

// File: tb/tb_multi_alarm_clock.sv
// ============================================================================
// Module   : tb_multi_alarm_clock
// Brief    : Scoreboard bench for multi_alarm_clock; one fast instance and one
//            prescaled three-slot instance share the panel inputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_alarm_clock;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] H_in1 = 2'd0;
    logic [3:0] H_in0 = 4'd0, M_in1 = 4'd0, M_in0 = 4'd0;
    logic       LD_time = 1'b0, LD_alarm = 1'b0;
    logic [1:0] al_sel = 2'd0;
    logic [3:0] AL_EN = 4'd0;
    logic       STOP_al = 1'b0, SNOOZE = 1'b0;

    logic       a_alarm, b_alarm;
    logic [3:0] a_id;
    logic [2:0] b_id;
    logic [1:0] a_h1, b_h1;
    logic [3:0] a_h0, a_m1, a_m0, a_s1, a_s0;
    logic [3:0] b_h0, b_m1, b_m0, b_s1, b_s0;

    always #5 clk = ~clk;

    multi_alarm_clock #(
        .CLK_DIV(1), .N_ALARMS(4), .SEL_W(2), .SNOOZE_MIN(1), .RING_SEC(10)
    ) dut_a (
        .clk(clk), .reset(reset), .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .al_sel(al_sel), .AL_EN(AL_EN),
        .STOP_al(STOP_al), .SNOOZE(SNOOZE), .Alarm(a_alarm), .Alarm_id(a_id),
        .H_out1(a_h1), .H_out0(a_h0), .M_out1(a_m1), .M_out0(a_m0), .S_out1(a_s1), .S_out0(a_s0)
    );

    multi_alarm_clock #(
        .CLK_DIV(4), .N_ALARMS(3), .SEL_W(2), .SNOOZE_MIN(5), .RING_SEC(60)
    ) dut_b (
        .clk(clk), .reset(reset), .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .al_sel(al_sel), .AL_EN(AL_EN[2:0]),
        .STOP_al(STOP_al), .SNOOZE(SNOOZE), .Alarm(b_alarm), .Alarm_id(b_id),
        .H_out1(b_h1), .H_out0(b_h0), .M_out1(b_m1), .M_out0(b_m0), .S_out1(b_s1), .S_out0(b_s0)
    );

    typedef struct {
        int          due;
        bit          use_b;
        string       tag;
        logic [23:0] t;
        logic        al;
        logic [3:0]  id;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] obs_time(input bit use_b);
        return use_b ? {2'b00, b_h1, b_h0, b_m1, b_m0, b_s1, b_s0}
                     : {2'b00, a_h1, a_h0, a_m1, a_m0, a_s1, a_s0};
    endfunction

    // n = number of further clock edges after which the outputs must match
    task automatic expect_at(input int n, input bit use_b, input string tag,
                             input logic [23:0] t, input logic al, input logic [3:0] id);
        exp_t e;
        e.due   = cyc + n;
        e.use_b = use_b;
        e.tag   = tag;
        e.t     = t;
        e.al    = al;
        e.id    = id;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due < cyc) begin
                check({sb[i].tag, ".missed"}, cyc, sb[i].due);
                sb.delete(i);
            end else if (sb[i].due == cyc) begin
                check({sb[i].tag, ".time"}, {8'h0, obs_time(sb[i].use_b)}, {8'h0, sb[i].t});
                check({sb[i].tag, ".alarm"}, sb[i].use_b ? b_alarm : a_alarm, sb[i].al);
                check({sb[i].tag, ".id"}, sb[i].use_b ? {1'b0, b_id} : a_id, sb[i].id);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_hm(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1,
                          input logic [3:0] m0);
        H_in1 = h1;
        H_in0 = h0;
        M_in1 = m1;
        M_in0 = m0;
    endtask

    task automatic ld_time(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1,
                           input logic [3:0] m0);
        set_hm(h1, h0, m1, m0);
        LD_time = 1'b1;
        step(1);
        LD_time = 1'b0;
    endtask

    task automatic ld_alarm(input logic [1:0] sel, input logic [1:0] h1, input logic [3:0] h0,
                            input logic [3:0] m1, input logic [3:0] m0);
        set_hm(h1, h0, m1, m0);
        al_sel   = sel;
        LD_alarm = 1'b1;
        step(1);
        LD_alarm = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "bench did not complete");
    end

    initial begin
        step(2);
        expect_at(0, 0, "a_reset", 24'h000000, 1'b0, 4'd0);
        expect_at(0, 1, "b_reset", 24'h000000, 1'b0, 4'd0);
        reset = 1'b0;

        // day wrap and a plain minute carry
        ld_time(2'd2, 4'd3, 4'd5, 4'd9);
        expect_at(0, 0, "t1_load", 24'h235900, 1'b0, 4'd0);
        expect_at(59, 0, "t1_235959", 24'h235959, 1'b0, 4'd0);
        expect_at(60, 0, "t1_wrap", 24'h000000, 1'b0, 4'd0);
        step(60);
        ld_time(2'd1, 4'd0, 4'd1, 4'd9);
        expect_at(0, 0, "t1_ld1019", 24'h101900, 1'b0, 4'd0);
        expect_at(60, 0, "t1_1020", 24'h102000, 1'b0, 4'd0);
        step(60);

        // single slot ring and stop
        ld_alarm(2'd2, 2'd1, 4'd0, 4'd2, 4'd0);
        AL_EN = 4'b0100;
        ld_time(2'd1, 4'd0, 4'd1, 4'd9);
        expect_at(59, 0, "t2_pre", 24'h101959, 1'b0, 4'd0);
        expect_at(60, 0, "t2_ring", 24'h102000, 1'b1, 4'b0100);
        expect_at(65, 0, "t2_ring5", 24'h102005, 1'b1, 4'b0100);
        step(65);
        STOP_al = 1'b1;
        expect_at(1, 0, "t2_stop", 24'h102006, 1'b0, 4'd0);
        step(1);
        STOP_al = 1'b0;

        // snooze one minute, re-ring, auto-timeout after 10 s
        AL_EN = 4'b0001;
        ld_alarm(2'd0, 2'd1, 4'd0, 4'd2, 4'd0);
        ld_time(2'd1, 4'd0, 4'd1, 4'd9);
        expect_at(60, 0, "t3_ring", 24'h102000, 1'b1, 4'b0001);
        expect_at(63, 0, "t3_ring3", 24'h102003, 1'b1, 4'b0001);
        step(63);
        SNOOZE = 1'b1;
        expect_at(1, 0, "t3_snoozed", 24'h102004, 1'b0, 4'b0001);
        expect_at(60, 0, "t3_snz_last", 24'h102103, 1'b0, 4'b0001);
        expect_at(61, 0, "t3_rering", 24'h102104, 1'b1, 4'b0001);
        expect_at(70, 0, "t3_ring_last", 24'h102113, 1'b1, 4'b0001);
        expect_at(71, 0, "t3_timeout", 24'h102114, 1'b0, 4'd0);
        step(1);
        SNOOZE = 1'b0;
        step(70);

        // two slots together, then enables withdrawn one at a time
        ld_alarm(2'd1, 2'd1, 4'd0, 4'd2, 4'd0);
        AL_EN = 4'b0011;
        ld_time(2'd1, 4'd0, 4'd1, 4'd9);
        expect_at(60, 0, "t4_both", 24'h102000, 1'b1, 4'b0011);
        step(60);
        AL_EN = 4'b0010;
        expect_at(1, 0, "t4_clr0", 24'h102001, 1'b1, 4'b0010);
        step(1);
        AL_EN = 4'b0000;
        expect_at(1, 0, "t4_clr1", 24'h102002, 1'b0, 4'd0);
        step(1);
        AL_EN = 4'b0011;
        expect_at(1, 0, "t4_idle", 24'h102003, 1'b0, 4'd0);
        step(1);

        // invalid loads are dropped, time keeps counting
        AL_EN = 4'b0000;
        ld_time(2'd1, 4'd2, 4'd0, 4'd0);
        expect_at(0, 0, "t5_ld1200", 24'h120000, 1'b0, 4'd0);
        ld_time(2'd2, 4'd4, 4'd0, 4'd0);
        expect_at(0, 0, "t5_h24", 24'h120001, 1'b0, 4'd0);
        ld_time(2'd3, 4'd0, 4'd0, 4'd0);
        expect_at(0, 0, "t5_h30", 24'h120002, 1'b0, 4'd0);
        ld_time(2'd1, 4'd2, 4'd6, 4'd0);
        expect_at(0, 0, "t5_m60", 24'h120003, 1'b0, 4'd0);
        ld_time(2'd1, 4'd2, 4'd0, 4'hA);
        expect_at(0, 0, "t5_m0a", 24'h120004, 1'b0, 4'd0);

        // both loads together: slot 3 must stay at 00:00 and not ring at 07:45
        set_hm(2'd0, 4'd7, 4'd4, 4'd4);
        al_sel   = 2'd3;
        LD_time  = 1'b1;
        LD_alarm = 1'b1;
        step(1);
        LD_time  = 1'b0;
        LD_alarm = 1'b0;
        AL_EN    = 4'b1000;
        expect_at(0, 0, "t5_both_ld", 24'h074400, 1'b0, 4'd0);
        expect_at(60, 0, "t5_slot3", 24'h074500, 1'b0, 4'd0);
        step(60);

        AL_EN = 4'b0001;
        ld_time(2'd1, 4'd0, 4'd2, 4'd0);
        expect_at(0, 0, "t5_ld_nomatch", 24'h102000, 1'b0, 4'd0);
        ld_time(2'd1, 4'd0, 4'd1, 4'd9);
        expect_at(60, 0, "t5_ring", 24'h102000, 1'b1, 4'b0001);
        step(60);
        ld_time(2'd0, 4'd9, 4'd0, 4'd0);
        expect_at(0, 0, "t5_ld_in_ring", 24'h090000, 1'b1, 4'b0001);
        STOP_al = 1'b1;
        SNOOZE  = 1'b1;
        expect_at(1, 0, "t5_stop_snz", 24'h090001, 1'b0, 4'd0);
        expect_at(3, 0, "t5_stays_idle", 24'h090003, 1'b0, 4'd0);
        step(1);
        STOP_al = 1'b0;
        SNOOZE  = 1'b0;
        step(2);

        // prescaled instance: restart both from reset
        reset = 1'b1;
        step(2);
        expect_at(0, 1, "t6_reset", 24'h000000, 1'b0, 4'd0);
        reset = 1'b0;
        ld_alarm(2'd3, 2'd1, 4'd0, 4'd2, 4'd0);
        AL_EN = 4'b0111;
        ld_time(2'd1, 4'd0, 4'd1, 4'd9);
        expect_at(0, 1, "t6_ld", 24'h101900, 1'b0, 4'd0);
        expect_at(3, 1, "t6_hold", 24'h101900, 1'b0, 4'd0);
        expect_at(4, 1, "t6_adv", 24'h101901, 1'b0, 4'd0);
        expect_at(7, 1, "t6_hold2", 24'h101901, 1'b0, 4'd0);
        expect_at(8, 1, "t6_adv2", 24'h101902, 1'b0, 4'd0);
        step(11);
        // this load lands on a tick edge: no advance, prescaler restarts
        ld_time(2'd1, 4'd0, 4'd1, 4'd9);
        expect_at(0, 1, "t6_ld_tick", 24'h101900, 1'b0, 4'd0);
        expect_at(3, 1, "t6_mid_hold", 24'h101900, 1'b0, 4'd0);
        expect_at(4, 1, "t6_mid_adv", 24'h101901, 1'b0, 4'd0);
        expect_at(240, 1, "t6_sel3", 24'h102000, 1'b0, 4'd0);
        step(241);

        ld_alarm(2'd0, 2'd1, 4'd0, 4'd2, 4'd0);
        ld_time(2'd1, 4'd0, 4'd1, 4'd9);
        expect_at(239, 1, "t6_pre", 24'h101959, 1'b0, 4'd0);
        expect_at(240, 1, "t6_ring", 24'h102000, 1'b1, 4'b0001);
        expect_at(242, 1, "t6_ringing", 24'h102000, 1'b1, 4'b0001);
        step(242);
        reset = 1'b1;
        expect_at(1, 1, "t6_rst_ring", 24'h000000, 1'b0, 4'd0);
        step(1);
        reset = 1'b0;

        step(3);
        check("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multi_alarm_clock.md
Name: multi_alarm_clock

Overview:
Parametrised successor to the single-alarm BCD clock. Keeps a 24-hour HH:MM:SS time-of-day in BCD and advances it from a prescaled system clock. Holds N_ALARMS independently enabled alarm slots and drives one shared ring FSM with snooze and auto-timeout. Sits between the front-panel input decoder (BCD digits, load and stop strobes) and the display/buzzer drivers.

Parameters:
CLK_DIV, 1, clk cycles per second; tick is asserted when the prescaler equals CLK_DIV-1 (with 1, every cycle is a tick)
N_ALARMS, 4, number of alarm slots (2..8)
SEL_W, 2, width of al_sel; must be at least clog2(N_ALARMS)
SNOOZE_MIN, 5, snooze length in minutes (1..9)
RING_SEC, 60, ring duration in seconds before auto-stop (1..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
H_in1  in  2  hour tens digit, BCD
H_in0  in  4  hour units digit, BCD
M_in1  in  4  minute tens digit, BCD
M_in0  in  4  minute units digit, BCD
LD_time  in  1  load H_in:M_in into the time; seconds load as 00
LD_alarm  in  1  load H_in:M_in into slot al_sel
al_sel  in  SEL_W  target slot for LD_alarm
AL_EN  in  N_ALARMS  per-slot enable (level)
STOP_al  in  1  stop ringing or snooze
SNOOZE  in  1  snooze the current ring
Alarm  out  1  buzzer drive, high while in RING
Alarm_id  out  N_ALARMS  mask of ringing/snoozed slots
H_out1  out  2  time, hour tens digit
H_out0  out  4  time, hour units digit
M_out1  out  4  time, minute tens digit
M_out0  out  4  time, minute units digit
S_out1  out  4  time, second tens digit
S_out0  out  4  time, second units digit

Behaviour:
- Clocking: one clock. Reset is synchronous, active-high, and has priority over everything else.
- Reset values: time 00:00:00, all slots 00:00, prescaler 0, FSM IDLE, Alarm=0, Alarm_id=0. Reset mid-ring or mid-snooze returns to IDLE on the same edge.
- Time counting:
  - On each tick the time advances 1 s, carrying through BCD.
  - S rolls 59->00 and carries into minutes; M rolls 59->00 and carries into hours.
  - 23:59:59 wraps to 00:00:00.
  - Outputs are registered; there is no combinational path from inputs to outputs.
- Input validity: a load is valid only if H <= 23, M_in1 <= 5 and M_in0 <= 9. An invalid LD_time or LD_alarm is ignored entirely; nothing changes.
- LD_time (valid):
  - Time becomes H:M:00 on that edge and the prescaler clears to 0.
  - The time does not advance in that cycle.
  - A load never triggers a match.
- LD_alarm (valid): slot[al_sel] becomes H:M. If al_sel >= N_ALARMS the load is ignored.
- Simultaneous loads: if LD_time and LD_alarm are asserted in the same cycle, only LD_time takes effect.
- Match condition:
  - m[k] is set on a tick whose next time equals slot[k]:00 while AL_EN[k]=1.
  - Alarm rises on the same edge that the display shows HH:MM:00.
- FSM states: IDLE, RING, SNOOZED.
  - IDLE: any m -> RING; mask = m; ring timer = 0.
  - RING (Alarm=1): timer increments on each tick.
  - RING -> IDLE (mask cleared) on STOP_al.
  - RING -> SNOOZED on SNOOZE; snooze counter = SNOOZE_MIN*60.
  - RING -> IDLE (mask cleared) when the timer reaches RING_SEC.
  - RING, new match: mask |= m; timer = 0.
  - SNOOZED (Alarm=0, Alarm_id keeps the mask): counter decrements on each tick.
  - SNOOZED -> RING when the counter reaches 0, with the same mask and timer = 0.
  - SNOOZED -> IDLE on STOP_al.
  - SNOOZED, new match: -> RING; mask |= m; timer = 0.
- STOP_al and SNOOZE in the same cycle: STOP_al wins.
- SNOOZE in IDLE is ignored.
- Clearing AL_EN[k] clears mask bit k on the next edge. If the mask becomes 0, the FSM goes to IDLE.
- LD_time during RING or SNOOZED does not affect the FSM or its timers.
- Alarm = (state==RING). Alarm_id = mask when the state is not IDLE, otherwise 0.

Test Plan:
1. CLK_DIV=1: reset; LD_time 23:59; run 60 cycles -> display 00:00:00; LD_time 10:19 then 60 cycles -> 10:20:00.
2. Slot 2 = 10:20, AL_EN=0100, LD_time 10:19 -> Alarm rises on the edge showing 10:20:00 with Alarm_id=0100; STOP_al at 10:20:05 -> Alarm=0 and Alarm_id=0000 on the next edge.
3. SNOOZE_MIN=1, RING_SEC=10, slot 0 = 10:20, AL_EN=0001: SNOOZE sampled while 10:20:03 is shown -> Alarm=0 and Alarm_id=0001; Alarm re-rises when 10:21:04 is shown; with no stop it drops when 10:21:14 is shown.
4. Slots 0 and 1 = 10:20, AL_EN=0011 -> Alarm_id=0011; clear AL_EN[0] -> Alarm_id=0010, Alarm=1; clear AL_EN[1] -> Alarm=0, FSM in IDLE.
5. LD_time with H=24 -> ignored, time keeps counting; LD_time and LD_alarm in the same cycle -> time loaded, slot unchanged; LD_alarm with al_sel=3 and N_ALARMS=3 -> ignored; STOP_al and SNOOZE together -> IDLE.
6. CLK_DIV=4: seconds advance every 4th cycle; LD_time asserted mid-count -> the next advance comes exactly 4 cycles after the load; reset asserted during RING -> 00:00:00 and Alarm=0 on the same edge.
